pc_ifid_stage: RTL

// - Consumer of the hazard unit's stall/bubble outputs: owns the PC register and the IF/ID pipeline register.
// - Applies PCWr/IFIDWr holds and ID-stage redirects (taken branch, jump, jr/jalr), and inserts NOP bubbles on flush.
// - Tracks stall episodes with a small FSM and raises a sticky watchdog error on runaway stalls.
// - Sits between instruction memory (combinational read at PC) and the ID stage.

---
 rtl/pc_ifid_stage_pkg.sv | 35 +++
 rtl/pc_ifid_stage_perf_counter.sv | 34 +++
 rtl/pc_ifid_stage.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/pc_ifid_stage_pkg.sv
// -----------------------------------------------------------------------------
// pc_ifid_stage_pkg
// Shared types and constants for the fetch stage (PC register + IF/ID register).
//   ifs_state_e   : stall-episode tracker states (RUN / STALL / FLUSH)
//   NOP_INS       : instruction word written into IF/ID on a flush (sll $0,$0,0)
//   STALL_LEN_SAT : saturation value of the stall-length counter
//   word_align()  : clears the byte-offset bits of a redirect target
//   stall_len_inc(): saturating increment of the stall-length counter
// -----------------------------------------------------------------------------
package pc_ifid_stage_pkg;

    typedef enum logic [1:0] {
        IFS_RUN   = 2'b00,
        IFS_STALL = 2'b01,
        IFS_FLUSH = 2'b10
    } ifs_state_e;

    localparam logic [31:0] NOP_INS       = 32'h0000_0000;
    localparam logic [7:0]  STALL_LEN_SAT = 8'd255;
    localparam logic [31:0] PC_STEP       = 32'd4;

    // Redirect targets are word addresses; the low two bits carry no meaning.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

    function automatic logic [7:0] stall_len_inc(input logic [7:0] len);
        if (len == STALL_LEN_SAT) begin
            return STALL_LEN_SAT;
        end else begin
            return len + 8'd1;
        end
    endfunction

endpackage

// File: rtl/pc_ifid_stage_perf_counter.sv
// -----------------------------------------------------------------------------
// perf_counter
// Free-running event counter with synchronous clear; wraps at 2^W.
// Ports:
//   clk    in  1  clock
//   i_clr  in  1  synchronous clear (highest priority)
//   i_inc  in  1  count enable for this cycle
//   o_cnt  out W  current count (registered)
// -----------------------------------------------------------------------------
module perf_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    // Count register: clear, increment, or hold.
    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + {{(W-1){1'b0}}, 1'b1};
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/pc_ifid_stage.sv
// -----------------------------------------------------------------------------
// pc_ifid_stage
// Owns the program counter and the IF/ID pipeline register. Applies the hazard
// unit's PCWr/IFIDWr holds, ID-stage redirects (branch/jump/jr), inserts NOP
// bubbles on a redirect, tracks stall episodes and raises a sticky watchdog
// flag when a stall runs for MAX_STALL consecutive cycles.
//
// Optional feature macro: PERF_CNT_EN (performance counters). When undefined
// the Perf* outputs are tied to zero.
//
// Ports:
//   clk           in   1      clock, rising edge
//   rst           in   1      synchronous active-high reset
//   PCWr          in   1      1 = PC may advance
//   IFIDWr        in   1      1 = IF/ID may load
//   Redirect      in   1      ID resolved a taken branch/jump this cycle
//   RedirectPC    in   32     redirect target (bits [1:0] ignored)
//   IMIns         in   32     instruction memory data at PC
//   PC            out  32     fetch address
//   IFIDPC        out  32     PC of the instruction in IF/ID
//   IFIDPCPlus4   out  32     IFIDPC + 4, registered
//   IFIDIns       out  32     instruction in IF/ID (NOP when bubble)
//   IFIDValid     out  1      IFIDIns is a real fetched instruction
//   StallTimeout  out  1      sticky runaway-stall flag, cleared by rst only
//   PerfStallCnt  out  CNT_W  cycles with PCWr==0 and no Redirect
//   PerfFlushCnt  out  CNT_W  cycles with Redirect==1
//   PerfFetchCnt  out  CNT_W  cycles IF/ID loaded a valid instruction
// -----------------------------------------------------------------------------
module pc_ifid_stage
    import pc_ifid_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter int          MAX_STALL = 16,
    parameter int          CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             PCWr,
    input  logic             IFIDWr,
    input  logic             Redirect,
    input  logic [31:0]      RedirectPC,
    input  logic [31:0]      IMIns,
    output logic [31:0]      PC,
    output logic [31:0]      IFIDPC,
    output logic [31:0]      IFIDPCPlus4,
    output logic [31:0]      IFIDIns,
    output logic             IFIDValid,
    output logic             StallTimeout,
    output logic [CNT_W-1:0] PerfStallCnt,
    output logic [CNT_W-1:0] PerfFlushCnt,
    output logic [CNT_W-1:0] PerfFetchCnt
);

    localparam logic [7:0] MAX_STALL_L = 8'(MAX_STALL);

    logic [31:0] r_pc;
    logic [31:0] r_ifid_pc;
    logic [31:0] r_ifid_pc4;
    logic [31:0] r_ifid_ins;
    logic        r_ifid_valid;
    logic        r_timeout;
    ifs_state_e  r_state;
    logic [7:0]  r_stall_len;

    ifs_state_e  w_state_nxt;
    logic [7:0]  w_stall_len_nxt;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_redirect_pc;
    logic        w_pc_hold;
    logic        w_timeout_hit;

    assign w_pc_plus4    = r_pc + PC_STEP;
    assign w_redirect_pc = word_align(RedirectPC);
    // PCWr=1 with IFIDWr=0 is not a legal hazard-unit combination; freezing
    // the PC as well keeps PC and IF/ID consistent instead of skipping a slot.
    assign w_pc_hold     = !PCWr || !IFIDWr;

    // PC register: reset > redirect > hold > sequential advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (Redirect) begin
            r_pc <= w_redirect_pc;
        end else if (w_pc_hold) begin
            r_pc <= r_pc;
        end else begin
            r_pc <= w_pc_plus4;
        end
    end

    // IF/ID register: reset > flush to bubble > hold > load the fetched slot.
    // On a flush only the instruction/valid are cleared; the PC fields keep
    // their previous value since nothing downstream uses them for a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ifid_pc    <= 32'h0000_0000;
            r_ifid_pc4   <= 32'h0000_0000;
            r_ifid_ins   <= NOP_INS;
            r_ifid_valid <= 1'b0;
        end else if (Redirect) begin
            r_ifid_pc    <= r_ifid_pc;
            r_ifid_pc4   <= r_ifid_pc4;
            r_ifid_ins   <= NOP_INS;
            r_ifid_valid <= 1'b0;
        end else if (!IFIDWr) begin
            r_ifid_pc    <= r_ifid_pc;
            r_ifid_pc4   <= r_ifid_pc4;
            r_ifid_ins   <= r_ifid_ins;
            r_ifid_valid <= r_ifid_valid;
        end else begin
            r_ifid_pc    <= r_pc;
            r_ifid_pc4   <= w_pc_plus4;
            r_ifid_ins   <= IMIns;
            r_ifid_valid <= 1'b1;
        end
    end

    // Stall-episode tracker: next state and stall length. A redirect always
    // wins so a flush is never swallowed by a concurrent stall request.
    always_comb begin
        w_state_nxt     = r_state;
        w_stall_len_nxt = r_stall_len;
        case (r_state)
            IFS_RUN, IFS_FLUSH: begin
                if (Redirect) begin
                    w_state_nxt     = IFS_FLUSH;
                    w_stall_len_nxt = 8'd0;
                end else if (!PCWr) begin
                    w_state_nxt     = IFS_STALL;
                    w_stall_len_nxt = 8'd1;
                end else begin
                    w_state_nxt     = IFS_RUN;
                    w_stall_len_nxt = 8'd0;
                end
            end
            IFS_STALL: begin
                if (Redirect) begin
                    w_state_nxt     = IFS_FLUSH;
                    w_stall_len_nxt = 8'd0;
                end else if (!PCWr) begin
                    w_state_nxt     = IFS_STALL;
                    w_stall_len_nxt = stall_len_inc(r_stall_len);
                end else begin
                    w_state_nxt     = IFS_RUN;
                    w_stall_len_nxt = 8'd0;
                end
            end
            default: begin
                w_state_nxt     = IFS_RUN;
                w_stall_len_nxt = 8'd0;
            end
        endcase
    end

    // Watchdog fires on the edge where the stall length becomes MAX_STALL.
    always_comb begin
        if ((w_state_nxt == IFS_STALL) && (w_stall_len_nxt == MAX_STALL_L)) begin
            w_timeout_hit = 1'b1;
        end else begin
            w_timeout_hit = 1'b0;
        end
    end

    // Tracker state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IFS_RUN;
            r_stall_len <= 8'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_stall_len <= w_stall_len_nxt;
        end
    end

    // Sticky watchdog flag; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timeout <= 1'b0;
        end else if (w_timeout_hit) begin
            r_timeout <= 1'b1;
        end else begin
            r_timeout <= r_timeout;
        end
    end

    assign PC           = r_pc;
    assign IFIDPC       = r_ifid_pc;
    assign IFIDPCPlus4  = r_ifid_pc4;
    assign IFIDIns      = r_ifid_ins;
    assign IFIDValid    = r_ifid_valid;
    assign StallTimeout = r_timeout;

`ifdef PERF_CNT_EN
    logic w_stall_inc;
    logic w_flush_inc;
    logic w_fetch_inc;

    assign w_stall_inc = !PCWr && !Redirect;
    assign w_flush_inc = Redirect;
    assign w_fetch_inc = IFIDWr && !Redirect;

    perf_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .i_clr (rst),
        .i_inc (w_stall_inc),
        .o_cnt (PerfStallCnt)
    );

    perf_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .i_clr (rst),
        .i_inc (w_flush_inc),
        .o_cnt (PerfFlushCnt)
    );

    perf_counter #(.W(CNT_W)) u_fetch_cnt (
        .clk   (clk),
        .i_clr (rst),
        .i_inc (w_fetch_inc),
        .o_cnt (PerfFetchCnt)
    );
`else
    assign PerfStallCnt = '0;
    assign PerfFlushCnt = '0;
    assign PerfFetchCnt = '0;
`endif

endmodule
